// File: rtl/ram_loader.sv
// ram_loader: streams a 64-word 8x8 matrix into a RAM through a valid/ready input.
//   Parameter SIZE : data word width (default 16)
//   Ports:
//     clock      in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   one-cycle request to begin a load
//     abort      in   cancel a load in progress
//     in_data    in   stream data word
//     in_valid   in   in_data valid
//     in_ready   out  a word is accepted this cycle if in_valid is high
//     W_data     out  RAM write data (registered)
//     Wi_address out  RAM row index (registered)
//     Wj_address out  RAM column index (registered)
//     Wen        out  RAM write enable (registered)
//     busy       out  high while loading
//     done       out  one-cycle pulse after the 64th word
//     count      out  words accepted in the current load, 0..64
//   Macro LOADER_TRANSPOSE_EN: column-major addressing, so the RAM holds the transpose.
module ram_loader #(
  parameter int SIZE = 16
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] W_data,
  output logic [2:0]      Wi_address,
  output logic [2:0]      Wj_address,
  output logic            Wen,
  output logic            busy,
  output logic            done,
  output logic [6:0]      count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic accept;
  assign in_ready = (state == LOAD) && !abort;
  assign accept = in_valid && in_ready;
  assign busy = (state == LOAD);
  assign done = (state == DONE);
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      Wen <= 1'b0;
      W_data <= '0;
      Wi_address <= '0;
      Wj_address <= '0;
    end else begin
      // write lags the accept by one cycle; address comes from the pre-increment count
      Wen <= accept;
      if (accept) begin
        W_data <= in_data;
`ifdef LOADER_TRANSPOSE_EN
        Wi_address <= count[2:0];
        Wj_address <= count[5:3];
`else
        Wi_address <= count[5:3];
        Wj_address <= count[2:0];
`endif
      end
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          count <= '0;
        end
        LOAD: if (abort) state <= IDLE;
          else if (accept) begin
            count <= count + 7'd1;
            if (count == 7'd63) state <= DONE;
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader; driver queues expected writes, monitor checks them.
module tb_ram_loader;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] W_data;
  logic [2:0]  Wi_address;
  logic [2:0]  Wj_address;
  logic        Wen;
  logic        busy;
  logic        done;
  logic [6:0]  count;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  i;
    logic [2:0]  j;
    logic        dn;
  } wr_t;

  wr_t q[$];
  int compared = 0;
  int mismatched = 0;
  int done_pulses = 0;
  int model_cnt = 0;

  ram_loader #(.SIZE(16)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .W_data(W_data), .Wi_address(Wi_address), .Wj_address(Wj_address),
    .Wen(Wen), .busy(busy), .done(done), .count(count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rst_n) begin
      if (Wen) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL write: unexpected Wen data=%h i=%0d j=%0d", W_data, Wi_address, Wj_address);
        end else begin
          wr_t e;
          e = q.pop_front();
          if (W_data !== e.d || Wi_address !== e.i || Wj_address !== e.j || done !== e.dn) begin
            mismatched++;
            $display("FAIL write: got data=%h i=%0d j=%0d done=%b want data=%h i=%0d j=%0d done=%b",
                     W_data, Wi_address, Wj_address, done, e.d, e.i, e.j, e.dn);
          end
        end
      end else if (done) begin
        compared++;
        mismatched++;
        $display("FAIL done: pulse without matching write");
      end
      if (done) done_pulses++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [15:0] d);
    wr_t e;
    logic [5:0] k;
    k = model_cnt[5:0];
    e.d = d;
`ifdef LOADER_TRANSPOSE_EN
    e.i = k[2:0];
    e.j = k[5:3];
`else
    e.i = k[5:3];
    e.j = k[2:0];
`endif
    e.dn = (model_cnt == 63);
    q.push_back(e);
    model_cnt++;
  endtask

  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data = d;
    push_beat(d);
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_cnt = 0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_wen", Wen, 0);
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wdata", W_data, 0);
    chk("reset_addr", {Wi_address, Wj_address}, 0);
    rst_n = 1'b1;
    step();

    // back-to-back full load
    do_start();
    chk("a_busy", busy, 1);
    chk("a_count0", count, 0);
    for (int k = 0; k < 64; k++) beat(16'(k));
    in_valid = 1'b0;
    chk("a_count64", count, 64);
    chk("a_done", done, 1);
    chk("a_wen63", Wen, 1);
    step();
    chk("a_idle", busy | done, 0);

    // in_valid toggled through a full load
    do_start();
    for (int c = 0; c < 128; c++) begin
      if (c % 2 == 0) beat(16'h0100 + 16'(c / 2));
      else begin
        in_valid = 1'b0;
        if (c == 1) chk("b_ready_no_valid", in_ready, 1);
        step();
      end
    end
    chk("b_count64", count, 64);
    chk("b_idle", busy, 0);

    // abort after 20 accepts
    do_start();
    for (int k = 0; k < 20; k++) beat(16'h0200 + 16'(k));
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hdead;
    #1;
    chk("c_ready_abort", in_ready, 0);
    step();
    in_valid = 1'b0;
    chk("c_busy", busy, 0);
    chk("c_count20", count, 20);
    step();
    chk("c_abort_idle_ignored", busy, 0);
    abort = 1'b0;
    step();
    chk("c_count_hold", count, 20);
    do_start();
    chk("c_restart_count", count, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("c_abort2", busy, 0);

    // reset mid-load with an accept on the preceding edge
    do_start();
    for (int k = 0; k < 10; k++) beat(16'h0300 + 16'(k));
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    chk("d_rst_wen", Wen, 0);
    chk("d_rst_count", count, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_wdata", W_data, 0);
    chk("d_rst_addr", {Wi_address, Wj_address}, 0);
    step();
    step();
    rst_n = 1'b1;
    do_start();
    chk("d_restart_busy", busy, 1);
    for (int k = 0; k < 64; k++) beat(16'h0400 + 16'(k));
    in_valid = 1'b0;
    chk("d_done", done, 1);
    step();

    // start ignored in LOAD and DONE; start+abort in IDLE enters LOAD
    do_start();
    for (int k = 0; k < 5; k++) beat(16'h0500 + 16'(k));
    start = 1'b1;
    beat(16'h0505);
    start = 1'b0;
    chk("e_start_in_load", count, 6);
    for (int k = 6; k < 64; k++) beat(16'h0500 + 16'(k));
    in_valid = 1'b0;
    start = 1'b1;
    step();
    chk("e_start_in_done", busy, 0);
    start = 1'b0;
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    chk("e_start_abort_busy", busy, 1);
    chk("e_start_abort_count", count, 0);
    step();
    abort = 1'b0;
    chk("e_abort_end", busy, 0);

    for (int t = 0; t < 10 && q.size() != 0; t++) step();
    step();
    chk("queue_drained", q.size(), 0);
    chk("done_pulses", done_pulses, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
